// File: rtl/plru_table.sv
// Tree pseudo-LRU replacement table: WAYS-1 heap-ordered bits per set, victim read port, masked MRU update port.
// Optional macro PLRU_INVALID_FIRST_EN adds rd_way_vld_i; the lowest-numbered invalid way then wins over the PLRU victim.
//
// state   | meaning
// ST_INIT | sequencer sweeps every set to zero, one per cycle; requests ignored
// ST_RUN  | table live; reads and updates accepted
module plru_table #(
  parameter int DEPTH    = 256,
  parameter int INDEX_AW = 8,
  parameter int WAYS     = 4,
  parameter int WAY_AW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  output logic                ready_o,
  input  logic                rd_en_i,
  input  logic [INDEX_AW-1:0] rd_index_i,
`ifdef PLRU_INVALID_FIRST_EN
  input  logic [WAYS-1:0]     rd_way_vld_i,
`endif
  output logic                rd_vld_o,
  output logic [WAY_AW-1:0]   rd_victim_o,
  input  logic                upd_en_i,
  input  logic [INDEX_AW-1:0] upd_index_i,
  input  logic [WAY_AW-1:0]   upd_way_i
);

  localparam int NB = WAYS - 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state_q;
  logic [INDEX_AW-1:0] sweep_q;
  logic [NB-1:0]       mem [DEPTH];

  logic                run_acc;
  logic                wr_en;
  logic [INDEX_AW-1:0] wr_idx;
  logic [NB-1:0]       wr_mask;
  logic [NB-1:0]       wr_val;
  logic [NB-1:0]       upd_mask;
  logic [NB-1:0]       upd_val;
  logic [NB-1:0]       rd_state;
  logic [WAY_AW-1:0]   victim_next;

  // Walk from the root; each bit picks the half holding the victim.
  function automatic logic [WAY_AW-1:0] plru_victim(input logic [NB-1:0] s);
    logic [WAY_AW-1:0] way;
    logic [NB-1:0]     sh;
    int                node;
    way  = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_AW; lvl++) begin
      sh   = s >> node;
      way  = (way << 1) | WAY_AW'(sh[0]);
      node = 2 * node + 1 + int'(sh[0]);
    end
    return way;
  endfunction

  // Path nodes point away from the accessed way; off-path bits are left out of the mask.
  function automatic void plru_touch(input  logic [WAY_AW-1:0] w,
                                     output logic [NB-1:0]     mask,
                                     output logic [NB-1:0]     val);
    logic [WAY_AW-1:0] wsh;
    int                node;
    mask = '0;
    val  = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_AW; lvl++) begin
      wsh  = w >> (WAY_AW - 1 - lvl);
      mask = mask | (NB'(1) << node);
      if (!wsh[0]) val = val | (NB'(1) << node);
      node = 2 * node + 1 + int'(wsh[0]);
    end
  endfunction

  assign ready_o = (state_q == ST_RUN);
  assign run_acc = (state_q == ST_RUN) && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else if (flush_i) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else if (state_q == ST_INIT) begin
      if (sweep_q == INDEX_AW'(DEPTH - 1)) state_q <= ST_RUN;
      sweep_q <= sweep_q + 1'b1;
    end
  end

  always_comb begin
    plru_touch(upd_way_i, upd_mask, upd_val);
  end

  // Single write port: the sweep owns it in INIT, the update port in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = upd_index_i;
    wr_mask = upd_mask;
    wr_val  = upd_val;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        wr_en   = 1'b1;
        wr_idx  = sweep_q;
        wr_mask = '1;
        wr_val  = '0;
      end else begin
        wr_en = run_acc && upd_en_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_mask[b]) mem[wr_idx][b] <= wr_val[b];
      end
    end
  end

  // Write-first forwarding when a same-cycle update targets the looked-up set.
  always_comb begin
    rd_state = mem[rd_index_i];
    if (run_acc && upd_en_i && (upd_index_i == rd_index_i)) begin
      rd_state = (rd_state & ~upd_mask) | (upd_val & upd_mask);
    end
  end

`ifdef PLRU_INVALID_FIRST_EN
  logic [WAYS-1:0] vld_sh;
  always_comb begin
    victim_next = plru_victim(rd_state);
    for (int i = WAYS - 1; i >= 0; i--) begin
      vld_sh = rd_way_vld_i >> i;
      if (!vld_sh[0]) victim_next = WAY_AW'(i);
    end
  end
`else
  always_comb begin
    victim_next = plru_victim(rd_state);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_o    <= 1'b0;
      rd_victim_o <= '0;
    end else begin
      rd_vld_o <= run_acc && rd_en_i;
      if (run_acc && rd_en_i) rd_victim_o <= victim_next;
    end
  end

endmodule
